reg_file_ctrl: RTL and testbench
================================

REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

Interface
REQ-001 SHALL have parameter: DATA_W, 8, width of accumulator and register-file data.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: Reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: Instr  input  8  instruction byte: [7:6] opcode, [5:4] register index, [3:0] immediate.
REQ-005 SHALL have port: InstrValid  input  1  instruction offered.
REQ-006 SHALL have port: InstrReady  output  1  controller accepts an instruction this cycle.
REQ-007 SHALL have port: RegData  input  DATA_W  register-file read data, selected by RegX.
REQ-008 SHALL have port: RegX  output  4  one-hot register select to the register file.
REQ-009 SHALL have port: RegCE  output  1  register-file write strobe; the register file writes Aku into the RegX register.
REQ-010 SHALL have port: Aku  output  DATA_W  accumulator contents.
REQ-011 SHALL have port: Done  output  1  one-cycle pulse on instruction completion.
REQ-012 SHALL have port (REG_CTRL_CNT_EN only): InstrCnt  output  8  retired-instruction count.

Function
REQ-013 SHALL implement states IDLE, DECODE, EXEC, DONE; IDLE->DECODE on accept, DECODE->EXEC, EXEC->DONE, DONE->IDLE unconditionally.
REQ-014 SHALL drive InstrReady=1 only in IDLE; accept = InstrValid & InstrReady at a rising edge, latching Instr into an internal IR.
REQ-015 SHALL ignore InstrValid outside IDLE; no queuing, and Instr is not sampled.
REQ-016 SHALL use opcodes: 00 NOP, 01 ST (Aku->Rx), 10 LD (Rx->Aku), 11 LDI (Aku <= zero-extended IR[3:0]).
REQ-017 SHALL drive RegX = 1<<IR[5:4] in DECODE and EXEC for ST/LD, and 4'b0000 in every other state or opcode.
REQ-018 SHALL assert RegCE for exactly one cycle, in EXEC, for ST only; RegX is stable in that cycle.
REQ-019 SHALL load Aku from RegData on the EXEC->DONE edge for LD, and from the immediate on that edge for LDI.
REQ-020 SHALL leave Aku unchanged for NOP and ST.
REQ-021 SHALL assert Done for exactly the DONE cycle, for every opcode including NOP.
REQ-022 SHALL have a fixed latency: accept at edge N; DECODE during N..N+1; EXEC during N+1..N+2; Done during N+2..N+3; InstrReady returns after edge N+3.
REQ-023 SHALL drive RegX, RegCE, InstrReady and Done from state and IR only, with no combinational path from InstrValid or Instr.

Reset
REQ-024 SHALL, while Reset=1, asynchronously force: state IDLE, IR=0, Aku=0, RegX=0, RegCE=0, Done=0, and InstrCnt=0 when present.
REQ-025 SHALL, on Reset asserted mid-instruction, abandon that instruction with no RegCE pulse, no Aku update and no Done pulse.
REQ-026 SHALL drive InstrReady=1 in the first cycle after Reset deasserts.

Configuration
REQ-027 SHALL support macro REG_CTRL_CNT_EN: when defined, InstrCnt increments by 1 on each DONE->IDLE edge and wraps from 255 to 0; when undefined, the InstrCnt port and its counter are absent and all other behaviour is identical.

Verification
REQ-028 SHALL cover LDI then ST: Instr=8'hC5 then 8'h60 -> Aku=8'h05; RegX=4'b0100 with RegCE=1 for one cycle; two Done pulses.
REQ-029 SHALL cover LD: RegData=8'hA7 held, Instr=8'h90 -> RegX=4'b0010 during DECODE/EXEC; Aku=8'hA7 in the DONE cycle; RegCE never asserted.
REQ-030 SHALL cover back-to-back offers: InstrValid held high with 8'h00 -> accepts spaced exactly 4 cycles apart; Done each time; Aku unchanged.
REQ-031 SHALL cover a busy-time offer: InstrValid=1 with 8'hCF while in EXEC -> not accepted; Aku unaffected until re-accepted in IDLE.
REQ-032 SHALL cover reset in EXEC of ST 8'h70: Reset pulsed -> no RegCE, Aku=0, RegX=0, InstrReady=1 after release.
REQ-033 SHALL cover REG_CTRL_CNT_EN: 257 NOPs -> InstrCnt=1.

Source files
------------

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: accumulator-based controller for a four-entry register file.
// Each accepted instruction takes a fixed four-state trip: IDLE -> DECODE -> EXEC -> DONE.
//   opcode 00 NOP, 01 ST (Aku -> Rx), 10 LD (Rx -> Aku), 11 LDI (Aku <= imm4).
// Optional feature macro: REG_CTRL_CNT_EN adds the InstrCnt retired-instruction counter.
// Reset is asynchronous and active-high.

module reg_file_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [7:0]        Instr,
  input  logic              InstrValid,
  output logic              InstrReady,
  input  logic [DATA_W-1:0] RegData,
  output logic [3:0]        RegX,
  output logic              RegCE,
  output logic [DATA_W-1:0] Aku,
`ifdef REG_CTRL_CNT_EN
  output logic [7:0]        InstrCnt,
`endif
  output logic              Done
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StDecode = 2'b01,
    StExec   = 2'b10,
    StDone   = 2'b11
  } state_e;

  localparam logic [1:0] OpNop = 2'b00;
  localparam logic [1:0] OpSt  = 2'b01;
  localparam logic [1:0] OpLd  = 2'b10;
  localparam logic [1:0] OpLdi = 2'b11;

  state_e            state_q, state_d;
  logic [7:0]        ir_q;
  logic [DATA_W-1:0] aku_q, aku_d;
  logic              accept;
  logic [1:0]        ir_op;
  logic [1:0]        ir_reg;
  logic [3:0]        ir_imm;
  logic              uses_reg;

  assign ir_op  = ir_q[7:6];
  assign ir_reg = ir_q[5:4];
  assign ir_imm = ir_q[3:0];

  // Only IDLE listens to the offer; Instr is never looked at in other states.
  assign accept = InstrValid && (state_q == StIdle);

  // State register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed walk through the four states once an instruction is taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec:   state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Instruction register, captured only on accept
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      ir_q <= 8'h00;
    end else if (accept) begin
      ir_q <= Instr;
    end
  end

  // Accumulator next value: loads happen on the EXEC -> DONE edge only
  always_comb begin
    aku_d = aku_q;
    if (state_q == StExec) begin
      unique case (ir_op)
        OpLd:    aku_d = RegData;
        OpLdi:   aku_d = DATA_W'(ir_imm);
        OpNop,
        OpSt:    aku_d = aku_q;
        default: aku_d = aku_q;
      endcase
    end
  end

  // Accumulator register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      aku_q <= '0;
    end else begin
      aku_q <= aku_d;
    end
  end

  assign Aku = aku_q;

  // Outputs decoded from state and IR only, so no path from InstrValid/Instr exists
  always_comb begin
    uses_reg   = (ir_op == OpSt) || (ir_op == OpLd);
    InstrReady = (state_q == StIdle);
    Done       = (state_q == StDone);
    RegX       = 4'b0000;
    RegCE      = 1'b0;
    if (((state_q == StDecode) || (state_q == StExec)) && uses_reg) begin
      RegX = 4'b0001 << ir_reg;
    end
    // Single-cycle write strobe; RegX already settled since DECODE
    if ((state_q == StExec) && (ir_op == OpSt)) begin
      RegCE = 1'b1;
    end
  end

`ifdef REG_CTRL_CNT_EN
  logic [7:0] cnt_q;

  // Retired-instruction counter, bumps on DONE -> IDLE and wraps naturally
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= 8'h00;
    end else if (state_q == StDone) begin
      cnt_q <= cnt_q + 8'h01;
    end
  end

  assign InstrCnt = cnt_q;
`endif

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed self-checking bench for reg_file_ctrl.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.

module tb_reg_file_ctrl;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] Instr;
  logic       InstrValid;
  logic       InstrReady;
  logic [7:0] RegData;
  logic [3:0] RegX;
  logic       RegCE;
  logic [7:0] Aku;
  logic       Done;
`ifdef REG_CTRL_CNT_EN
  logic [7:0] InstrCnt;
`endif

  reg_file_ctrl #(.DATA_W(8)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .RegData    (RegData),
    .RegX       (RegX),
    .RegCE      (RegCE),
    .Aku        (Aku),
`ifdef REG_CTRL_CNT_EN
    .InstrCnt   (InstrCnt),
`endif
    .Done       (Done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-cycle observations of one instruction: 0 DECODE, 1 EXEC, 2 DONE, 3 back in IDLE
  logic [3:0] o_regx [4];
  logic       o_ce   [4];
  logic       o_done [4];
  logic       o_rdy  [4];
  logic [7:0] o_aku  [4];

  // Bounded wait for the controller to be idle
  task automatic wait_ready();
    int n = 0;
    while (!InstrReady && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (InstrReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got %b want 1", InstrReady);
    end
  endtask

  // Issue one instruction and record the four following falling-edge samples
  task automatic run_instr(input logic [7:0] ins);
    wait_ready();
    Instr      = ins;
    InstrValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      o_regx[i] = RegX;
      o_ce[i]   = RegCE;
      o_done[i] = Done;
      o_rdy[i]  = InstrReady;
      o_aku[i]  = Aku;
      if (i == 0) begin
        InstrValid = 1'b0;
        Instr      = ~ins;  // IR must hold the accepted byte
      end
    end
  endtask

  task automatic test_reset();
    Reset      = 1'b0;
    InstrValid = 1'b0;
    Instr      = 8'h00;
    RegData    = 8'h00;
    #1 Reset = 1'b1;
    @(negedge clk);
    checks++;
    if (RegX !== 4'b0000) begin errors++; $display("FAIL rst_regx got %b want 0000", RegX); end
    checks++;
    if (RegCE !== 1'b0) begin errors++; $display("FAIL rst_ce got %b want 0", RegCE); end
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", Done); end
    checks++;
    if (Aku !== 8'h00) begin errors++; $display("FAIL rst_aku got %h want 00", Aku); end
`ifdef REG_CTRL_CNT_EN
    checks++;
    if (InstrCnt !== 8'h00) begin errors++; $display("FAIL rst_cnt got %h want 00", InstrCnt); end
`endif
    Reset = 1'b0;
    #1;
    checks++;
    if (InstrReady !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", InstrReady); end
  endtask

  task automatic test_ldi_st();
    int dones = 0;
    run_instr(8'hC5);
    for (int i = 0; i < 4; i++) begin
      if (o_done[i]) dones++;
      checks++;
      if (o_regx[i] !== 4'b0000 || o_ce[i] !== 1'b0) begin
        errors++;
        $display("FAIL ldi_reg[%0d] got regx %b ce %b want 0000 0", i, o_regx[i], o_ce[i]);
      end
    end
    checks++;
    if (o_aku[2] !== 8'h05) begin errors++; $display("FAIL ldi_aku got %h want 05", o_aku[2]); end
    checks++;
    if (o_aku[1] !== 8'h00) begin errors++; $display("FAIL ldi_aku_early got %h want 00", o_aku[1]); end
    run_instr(8'h60);
    for (int i = 0; i < 4; i++) begin
      if (o_done[i]) dones++;
      checks++;
      if (o_regx[i] !== ((i < 2) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL st_regx[%0d] got %b want %b", i, o_regx[i], (i < 2) ? 4'b0100 : 4'b0000);
      end
      checks++;
      if (o_ce[i] !== (i == 1)) begin
        errors++;
        $display("FAIL st_ce[%0d] got %b want %b", i, o_ce[i], (i == 1));
      end
      checks++;
      if (o_aku[i] !== 8'h05) begin errors++; $display("FAIL st_aku[%0d] got %h want 05", i, o_aku[i]); end
    end
    checks++;
    if (o_done[2] !== 1'b1 || o_rdy[3] !== 1'b1 || o_rdy[2] !== 1'b0) begin
      errors++;
      $display("FAIL st_timing got done %b rdy %b%b want 1 01", o_done[2], o_rdy[2], o_rdy[3]);
    end
    checks++;
    if (dones !== 2) begin errors++; $display("FAIL ldi_st_dones got %0d want 2", dones); end
  endtask

  task automatic test_ld();
    RegData = 8'hA7;
    run_instr(8'h90);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_regx[i] !== ((i < 2) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL ld_regx[%0d] got %b want %b", i, o_regx[i], (i < 2) ? 4'b0010 : 4'b0000);
      end
      checks++;
      if (o_ce[i] !== 1'b0) begin errors++; $display("FAIL ld_ce[%0d] got %b want 0", i, o_ce[i]); end
      checks++;
      if (o_done[i] !== (i == 2)) begin
        errors++;
        $display("FAIL ld_done[%0d] got %b want %b", i, o_done[i], (i == 2));
      end
    end
    checks++;
    if (o_aku[1] !== 8'h05) begin errors++; $display("FAIL ld_aku_exec got %h want 05", o_aku[1]); end
    checks++;
    if (o_aku[2] !== 8'hA7) begin errors++; $display("FAIL ld_aku got %h want a7", o_aku[2]); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int dones = 0;
    wait_ready();
    Instr      = 8'h00;
    InstrValid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (InstrReady) acc.push_back(c);
      if (Done) dones++;
      @(negedge clk);
    end
    InstrValid = 1'b0;
    checks++;
    if (acc.size() !== 4) begin errors++; $display("FAIL b2b_accepts got %0d want 4", acc.size()); end
    for (int k = 1; k < acc.size(); k++) begin
      checks++;
      if (acc[k] - acc[k-1] !== 4) begin
        errors++;
        $display("FAIL b2b_spacing[%0d] got %0d want 4", k, acc[k] - acc[k-1]);
      end
    end
    checks++;
    if (dones !== 4) begin errors++; $display("FAIL b2b_dones got %0d want 4", dones); end
    checks++;
    if (Aku !== 8'hA7) begin errors++; $display("FAIL b2b_aku got %h want a7", Aku); end
  endtask

  task automatic test_busy_offer();
    wait_ready();
    Instr      = 8'h00;
    InstrValid = 1'b1;
    @(negedge clk);             // DECODE
    InstrValid = 1'b0;
    @(negedge clk);             // EXEC
    Instr      = 8'hCF;
    InstrValid = 1'b1;
    @(negedge clk);             // DONE
    checks++;
    if (InstrReady !== 1'b0 || Done !== 1'b1) begin
      errors++;
      $display("FAIL busy_done got rdy %b done %b want 0 1", InstrReady, Done);
    end
    checks++;
    if (Aku !== 8'hA7) begin errors++; $display("FAIL busy_aku_done got %h want a7", Aku); end
    @(negedge clk);             // IDLE, offer still up
    checks++;
    if (InstrReady !== 1'b1 || Aku !== 8'hA7) begin
      errors++;
      $display("FAIL busy_idle got rdy %b aku %h want 1 a7", InstrReady, Aku);
    end
    @(negedge clk);             // DECODE of CF
    InstrValid = 1'b0;
    checks++;
    if (InstrReady !== 1'b0) begin errors++; $display("FAIL busy_accept got %b want 0", InstrReady); end
    @(negedge clk);             // EXEC
    checks++;
    if (Aku !== 8'hA7) begin errors++; $display("FAIL busy_aku_exec got %h want a7", Aku); end
    @(negedge clk);             // DONE
    checks++;
    if (Aku !== 8'h0F || Done !== 1'b1) begin
      errors++;
      $display("FAIL busy_ldi got aku %h done %b want 0f 1", Aku, Done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    wait_ready();
    Instr      = 8'h70;
    InstrValid = 1'b1;
    @(negedge clk);             // DECODE
    InstrValid = 1'b0;
    checks++;
    if (RegX !== 4'b1000) begin errors++; $display("FAIL rmid_regx got %b want 1000", RegX); end
    @(posedge clk);             // entering EXEC
    #1 Reset = 1'b1;
    #1;
    checks++;
    if (RegCE !== 1'b0 || RegX !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_async got ce %b regx %b want 0 0000", RegCE, RegX);
    end
    checks++;
    if (Aku !== 8'h00 || Done !== 1'b0) begin
      errors++;
      $display("FAIL rmid_aku got aku %h done %b want 00 0", Aku, Done);
    end
    @(negedge clk);
    @(negedge clk);
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (InstrReady !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", InstrReady); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (RegCE !== 1'b0 || Done !== 1'b0 || Aku !== 8'h00 || InstrReady !== 1'b1) begin
        errors++;
        $display("FAIL rmid_after[%0d] got ce %b done %b aku %h rdy %b want 0 0 00 1",
                 i, RegCE, Done, Aku, InstrReady);
      end
    end
  endtask

`ifdef REG_CTRL_CNT_EN
  task automatic test_counter();
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    checks++;
    if (InstrCnt !== 8'h00) begin errors++; $display("FAIL cnt_rst got %h want 00", InstrCnt); end
    run_instr(8'h00);
    checks++;
    if (InstrCnt !== 8'h01) begin errors++; $display("FAIL cnt_one got %h want 01", InstrCnt); end
    for (int i = 0; i < 255; i++) run_instr(8'h00);
    checks++;
    if (InstrCnt !== 8'h00) begin errors++; $display("FAIL cnt_wrap got %h want 00", InstrCnt); end
    run_instr(8'h00);
    checks++;
    if (InstrCnt !== 8'h01) begin errors++; $display("FAIL cnt_257 got %h want 01", InstrCnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_ldi_st();
    test_ld();
    test_back_to_back();
    test_busy_offer();
    test_reset_mid();
`ifdef REG_CTRL_CNT_EN
    test_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
